// File: rtl/dbg_mem_arbiter.sv
// Shares one data-memory bus port between the core LSU and the debug module's
// system-bus path; debug drains the core, stalls it, then owns the bus.
module dbg_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [DW-1:0] core_rdata_o,
    output logic          core_hold_o,
    input  logic          dm_op_req_i,
    input  logic          dm_mem_we_i,
    input  logic [AW-1:0] dm_mem_addr_i,
    input  logic [DW-1:0] dm_mem_wdata_i,
    output logic [DW-1:0] dm_mem_rdata_o,
    output logic          dm_wr_overrun_o,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic          bus_gnt_i,
    input  logic          bus_rvalid_i,
    input  logic [DW-1:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        S_CORE,
        S_DRAIN,
        S_DBG,
        S_DBG_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          outstanding;
    logic          dbg_rd;
    logic          wbuf_valid;
    logic          wbuf_clr;
    logic [AW-1:0] wbuf_addr;
    logic [DW-1:0] wbuf_data;
    logic          accept;
    logic          rsp;

    // A response only counts when we issued the matching request; this drops
    // stale responses for transactions aborted by reset.
    assign rsp    = bus_rvalid_i & outstanding;
    assign accept = bus_req_o & bus_gnt_i;

    always_comb begin
        state_nxt     = state;
        core_hold_o   = 1'b1;
        core_gnt_o    = 1'b0;
        core_rvalid_o = 1'b0;
        core_rdata_o  = '0;
        bus_req_o     = 1'b0;
        bus_we_o      = 1'b0;
        bus_addr_o    = '0;
        bus_wdata_o   = '0;
        wbuf_clr      = 1'b0;

        case (state)
            S_CORE: begin
                core_hold_o = dm_op_req_i | wbuf_valid;
                bus_req_o   = core_req_i & ~core_hold_o;
                if (bus_req_o) begin
                    bus_we_o    = core_we_i;
                    bus_addr_o  = core_addr_i;
                    bus_wdata_o = core_wdata_i;
                end
                core_gnt_o    = bus_req_o & bus_gnt_i;
                core_rvalid_o = rsp;
                if (rsp) core_rdata_o = bus_rdata_i;
                // A response arriving this cycle already completes the core's
                // transaction, so there is nothing left to drain.
                if (core_hold_o) begin
                    if ((outstanding & ~rsp) | core_gnt_o) state_nxt = S_DRAIN;
                    else                                   state_nxt = S_DBG;
                end
            end

            S_DRAIN: begin
                core_rvalid_o = rsp;
                if (rsp) begin
                    core_rdata_o = bus_rdata_i;
                    state_nxt    = S_DBG;
                end
            end

            S_DBG: begin
                if (wbuf_valid) begin
                    bus_req_o   = 1'b1;
                    bus_we_o    = 1'b1;
                    bus_addr_o  = wbuf_addr;
                    bus_wdata_o = wbuf_data;
                    if (bus_gnt_i) begin
                        wbuf_clr  = 1'b1;
                        state_nxt = S_DBG_WAIT;
                    end
                end else if (dm_op_req_i) begin
                    bus_req_o  = 1'b1;
                    bus_addr_o = dm_mem_addr_i;
                    if (bus_gnt_i) state_nxt = S_DBG_WAIT;
                end else begin
                    state_nxt = S_CORE;
                end
            end

            S_DBG_WAIT: begin
                if (rsp) state_nxt = S_DBG;
            end

            default: state_nxt = S_CORE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_CORE;
            outstanding     <= 1'b0;
            dbg_rd          <= 1'b0;
            wbuf_valid      <= 1'b0;
            dm_wr_overrun_o <= 1'b0;
            dm_mem_rdata_o  <= '0;
        end else begin
            state <= state_nxt;

            if (accept)   outstanding <= 1'b1;
            else if (rsp) outstanding <= 1'b0;

            if (state == S_DBG && accept) dbg_rd <= ~bus_we_o;

            if (state == S_DBG_WAIT && rsp && dbg_rd) dm_mem_rdata_o <= bus_rdata_i;

            // A new capture beats a same-cycle drain; only an unconsumed entry
            // being replaced counts as an overrun.
            if (dm_mem_we_i) begin
                wbuf_valid <= 1'b1;
                if (wbuf_valid & ~wbuf_clr) dm_wr_overrun_o <= 1'b1;
            end else if (wbuf_clr) begin
                wbuf_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dm_mem_we_i) begin
            wbuf_addr <= dm_mem_addr_i;
            wbuf_data <= dm_mem_wdata_i;
        end
    end

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// Bench for dbg_mem_arbiter: directed scenarios, then random traffic against a
// transaction-level model of memory, debug write buffer and response routing.
module tb_dbg_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic        core_gnt_o, core_rvalid_o, core_hold_o;
    logic [31:0] core_rdata_o;
    logic        dm_op_req_i, dm_mem_we_i;
    logic [31:0] dm_mem_addr_i, dm_mem_wdata_i, dm_mem_rdata_o;
    logic        dm_wr_overrun_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int total = 0;
    int bad   = 0;

    dbg_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o), .core_hold_o(core_hold_o),
        .dm_op_req_i(dm_op_req_i), .dm_mem_we_i(dm_mem_we_i), .dm_mem_addr_i(dm_mem_addr_i),
        .dm_mem_wdata_i(dm_mem_wdata_i), .dm_mem_rdata_o(dm_mem_rdata_o),
        .dm_wr_overrun_o(dm_wr_overrun_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase
    logic [31:0] mem [0:15];
    logic        slv_busy, slv_core, slv_rd, slv_rv;
    int          slv_rem;
    logic [31:0] slv_data;
    int          cm_state;
    logic        wb_pend, ovr_m, stop;
    logic [31:0] wb_addr, wb_data, dm_m;
    logic [3:0]  ri;

    initial begin
        rst = 1'b1;
        core_req_i = 0; core_we_i = 0; core_addr_i = 0; core_wdata_i = 0;
        dm_op_req_i = 0; dm_mem_we_i = 0; dm_mem_addr_i = 0; dm_mem_wdata_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_bus_req", bus_req_o, 0);
        chk("rst_hold", core_hold_o, 0);
        chk("rst_core_gnt", core_gnt_o, 0);
        chk("rst_core_rvalid", core_rvalid_o, 0);
        chk("rst_dm_rdata", dm_mem_rdata_o, 0);
        chk("rst_ovr", dm_wr_overrun_o, 0);

        // Plain core read, gnt same cycle, rvalid two cycles later
        nxt(); core_req_i = 1; core_we_i = 0; core_addr_i = 32'h100; bus_gnt_i = 1; #1;
        chk("t1_gnt", core_gnt_o, 1); chk("t1_addr", bus_addr_o, 32'h100); chk("t1_hold", core_hold_o, 0);
        nxt(); core_req_i = 0; bus_gnt_i = 0; #1;
        chk("t1_gnt_off", core_gnt_o, 0); chk("t1_hold2", core_hold_o, 0);
        nxt(); bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF; #1;
        chk("t1_rvalid", core_rvalid_o, 1); chk("t1_rdata", core_rdata_o, 32'hDEADBEEF);
        chk("t1_hold3", core_hold_o, 0);
        nxt(); bus_rvalid_i = 0; bus_rdata_i = 0; #1;
        chk("t1_rvalid_off", core_rvalid_o, 0);

        // Debug request while core read outstanding: drain then debug read
        nxt(); core_req_i = 1; core_addr_i = 32'h104; bus_gnt_i = 1; #1;
        chk("t2_gnt", core_gnt_o, 1);
        nxt(); core_req_i = 0; bus_gnt_i = 0; dm_op_req_i = 1; dm_mem_addr_i = 32'h2000; #1;
        chk("t2_hold", core_hold_o, 1); chk("t2_noreq", bus_req_o, 0);
        nxt(); bus_rvalid_i = 1; bus_rdata_i = 32'h0BADF00D; #1;
        chk("t2_drain_req", bus_req_o, 0); chk("t2_core_rv", core_rvalid_o, 1);
        chk("t2_core_rd", core_rdata_o, 32'h0BADF00D);
        nxt(); bus_rvalid_i = 0; bus_rdata_i = 0; #1;
        chk("t2_dbg_req", bus_req_o, 1); chk("t2_dbg_we", bus_we_o, 0);
        chk("t2_dbg_addr", bus_addr_o, 32'h2000); chk("t2_core_rv_off", core_rvalid_o, 0);
        nxt(); bus_gnt_i = 1; #1;
        chk("t2_dbg_req2", bus_req_o, 1);
        nxt(); bus_gnt_i = 0; #1;
        chk("t2_wait_req", bus_req_o, 0);
        nxt(); bus_rvalid_i = 1; bus_rdata_i = 32'h12345678; #1;
        chk("t2_core_rv_dbg", core_rvalid_o, 0);
        nxt(); bus_rvalid_i = 0; bus_rdata_i = 0; #1;
        chk("t2_dm_rdata", dm_mem_rdata_o, 32'h12345678);

        // Debug op drops with empty buffer; pending core write granted on return
        nxt(); dm_op_req_i = 0; core_req_i = 1; core_we_i = 1; core_addr_i = 32'h200;
        core_wdata_i = 32'h0000CAFE; bus_gnt_i = 1; #1;
        chk("t5_dbg_noreq", bus_req_o, 0); chk("t5_hold", core_hold_o, 1); chk("t5_no_gnt", core_gnt_o, 0);
        nxt(); #1;
        chk("t5_hold_off", core_hold_o, 0); chk("t5_gnt", core_gnt_o, 1);
        chk("t5_we", bus_we_o, 1); chk("t5_wdata", bus_wdata_o, 32'h0000CAFE);
        nxt(); core_req_i = 0; core_we_i = 0; bus_gnt_i = 0;
        nxt(); bus_rvalid_i = 1; #1;
        chk("t5_rv", core_rvalid_o, 1);
        nxt(); bus_rvalid_i = 0;

        // Buffered debug write precedes a refresh read
        nxt(); dm_mem_we_i = 1; dm_mem_addr_i = 32'h3000; dm_mem_wdata_i = 32'hA5A5A5A5; #1;
        chk("t3_hold0", core_hold_o, 0);
        nxt(); dm_mem_we_i = 0; dm_mem_addr_i = 32'h2000; #1;
        chk("t3_hold", core_hold_o, 1); chk("t3_noreq", bus_req_o, 0);
        nxt(); dm_op_req_i = 1; bus_gnt_i = 1; #1;
        chk("t3_req", bus_req_o, 1); chk("t3_we", bus_we_o, 1);
        chk("t3_addr", bus_addr_o, 32'h3000); chk("t3_wdata", bus_wdata_o, 32'hA5A5A5A5);
        nxt(); dm_op_req_i = 0; bus_gnt_i = 0; #1;
        chk("t3_wait_req", bus_req_o, 0);
        nxt(); bus_rvalid_i = 1; bus_rdata_i = 32'hFFFFFFFF; #1;
        nxt(); bus_rvalid_i = 0; bus_rdata_i = 0; #1;
        chk("t3_dm_keep", dm_mem_rdata_o, 32'h12345678); chk("t3_ovr", dm_wr_overrun_o, 0);
        chk("t3_noreq2", bus_req_o, 0); chk("t3_hold2", core_hold_o, 1);
        nxt(); #1;
        chk("t3_back", core_hold_o, 0);

        // Back-to-back debug writes with bus stalled: overwrite + sticky overrun
        nxt(); dm_mem_we_i = 1; dm_mem_addr_i = 32'h4000; dm_mem_wdata_i = 32'h11111111; #1;
        nxt(); dm_mem_addr_i = 32'h4004; dm_mem_wdata_i = 32'h22222222; #1;
        chk("t4_noreq_c2", bus_req_o, 0);
        nxt(); dm_mem_we_i = 0; #1;
        chk("t4_req", bus_req_o, 1); chk("t4_we", bus_we_o, 1);
        chk("t4_addr", bus_addr_o, 32'h4004); chk("t4_wdata", bus_wdata_o, 32'h22222222);
        chk("t4_ovr", dm_wr_overrun_o, 1);
        nxt(); #1;
        chk("t4_req_held", bus_req_o, 1);
        nxt(); bus_gnt_i = 1;
        nxt(); bus_gnt_i = 0;
        nxt(); bus_rvalid_i = 1;
        nxt(); bus_rvalid_i = 0;
        nxt(); #1;
        chk("t4_ovr_sticky", dm_wr_overrun_o, 1); chk("t4_hold_off", core_hold_o, 0);

        // Reset while a debug read is outstanding; late response is dropped
        nxt(); dm_op_req_i = 1; dm_mem_addr_i = 32'h5000; #1;
        nxt(); bus_gnt_i = 1; #1;
        chk("t6_req", bus_req_o, 1); chk("t6_addr", bus_addr_o, 32'h5000);
        nxt(); bus_gnt_i = 0; dm_op_req_i = 0; rst = 1;
        nxt(); rst = 0; #1;
        chk("t6_bus_req", bus_req_o, 0); chk("t6_hold", core_hold_o, 0);
        chk("t6_core_gnt", core_gnt_o, 0); chk("t6_core_rv", core_rvalid_o, 0);
        chk("t6_dm_rdata", dm_mem_rdata_o, 0); chk("t6_ovr", dm_wr_overrun_o, 0);
        nxt(); bus_rvalid_i = 1; bus_rdata_i = 32'hBAD0BAD0; #1;
        chk("t6_late_rv", core_rvalid_o, 0); chk("t6_late_rd", core_rdata_o, 0);
        nxt(); bus_rvalid_i = 0; bus_rdata_i = 0; #1;
        chk("t6_dm_keep", dm_mem_rdata_o, 0);

        // Random traffic against the transaction-level model
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        slv_busy = 0; slv_core = 0; slv_rd = 0; slv_rem = 0; slv_data = 0;
        cm_state = 0; wb_pend = 0; ovr_m = 0; dm_m = 0; wb_addr = 0; wb_data = 0;
        for (int cyc = 0; cyc < 2100; cyc++) begin
            stop = (cyc >= 2000);
            @(posedge clk); #1;
            slv_rv = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
            if (slv_busy) begin
                slv_rem--;
                if (slv_rem == 0) begin
                    slv_rv = 1; bus_rvalid_i = 1; bus_rdata_i = slv_data;
                end
            end
            bus_gnt_i = !slv_busy && ($urandom_range(0, 2) != 0);
            if (cm_state != 1) core_req_i = 0;
            if (cm_state == 0 && !stop && $urandom_range(0, 3) == 0) begin
                ri = 4'($urandom_range(0, 15));
                core_req_i = 1; core_we_i = 1'($urandom_range(0, 1));
                core_addr_i = {26'd0, ri, 2'b00}; core_wdata_i = $urandom; cm_state = 1;
            end
            if (stop) dm_op_req_i = 0;
            else if ($urandom_range(0, 29) == 0) dm_op_req_i = !dm_op_req_i;
            if ($urandom_range(0, 7) == 0) begin
                ri = 4'($urandom_range(0, 15));
                dm_mem_addr_i = {26'd0, ri, 2'b00};
            end
            dm_mem_we_i = !stop && ($urandom_range(0, 9) == 0);
            if (dm_mem_we_i) begin
                ri = 4'($urandom_range(0, 15));
                dm_mem_addr_i = {26'd0, ri, 2'b00}; dm_mem_wdata_i = $urandom;
            end
            #1;
            chk("r_ovr", dm_wr_overrun_o, ovr_m);
            chk("r_dm_rdata", dm_mem_rdata_o, dm_m);
            chk("r_core_rv", core_rvalid_o, slv_rv && slv_core);
            chk("r_core_gnt", core_gnt_o, bus_req_o && bus_gnt_i && !core_hold_o);
            if (slv_rv) begin
                if (slv_core) begin
                    if (slv_rd) chk("r_core_rdata", core_rdata_o, slv_data);
                    cm_state = 0;
                end else if (slv_rd) begin
                    dm_m = slv_data;
                end
                slv_busy = 0;
            end
            if (bus_req_o && bus_gnt_i) begin
                slv_busy = 1; slv_rem = $urandom_range(1, 3);
                slv_core = !core_hold_o; slv_rd = !bus_we_o;
                if (slv_core) begin
                    chk("r_core_req_state", cm_state, 1);
                    chk("r_core_addr", bus_addr_o, core_addr_i);
                    chk("r_core_we", bus_we_o, core_we_i);
                    if (core_we_i) chk("r_core_wdata", bus_wdata_o, core_wdata_i);
                    cm_state = 2;
                end else if (bus_we_o) begin
                    chk("r_dbg_wr_pend", wb_pend, 1);
                    chk("r_dbg_wr_addr", bus_addr_o, wb_addr);
                    chk("r_dbg_wr_data", bus_wdata_o, wb_data);
                    wb_pend = 0;
                end else begin
                    chk("r_dbg_rd_prio", wb_pend, 0);
                    chk("r_dbg_rd_addr", bus_addr_o, dm_mem_addr_i);
                end
                if (bus_we_o) begin
                    mem[bus_addr_o[5:2]] = bus_wdata_o;
                    slv_data = $urandom;
                end else begin
                    slv_data = mem[bus_addr_o[5:2]];
                end
            end
            if (dm_mem_we_i) begin
                if (wb_pend) ovr_m = 1;
                wb_pend = 1; wb_addr = dm_mem_addr_i; wb_data = dm_mem_wdata_i;
            end
        end
        chk("end_core_idle", cm_state, 0);
        chk("end_wbuf_empty", wb_pend, 0);
        chk("end_hold", core_hold_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
